bus_mem_slave: RTL and testbench

BUS_MEM_SLAVE -- requirements
Module: bus_mem_slave

---
 rtl/bus_mem_if.sv | 19 +
 rtl/bus_mem_slave.sv | 101 ++++++++++
 tb/tb_bus_mem_slave.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bus_mem_if.sv
// Request/response bus between a crossbar slave port and a memory slave.
interface bus_mem_if;
    logic        req;
    logic [31:0] addr;
    logic        cmd;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, addr, cmd, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, addr, cmd, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/bus_mem_slave.sv
// Single-outstanding word memory slave with a fixed number of wait cycles before ack.
module bus_mem_slave #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic     clk,
    input  logic     reset,
    bus_mem_if.slave bus
);
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = 4;
    localparam logic        ZERO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx_q;
    logic             cmd_q;
    logic [31:0]      wdata_q;
    logic             ack_q;
    logic [31:0]      rdata_q;
    logic [31:0]      mem [DEPTH];

    logic             go_ack_c;
    logic [IDX_W-1:0] acc_idx_c;
    logic             acc_cmd_c;
    logic [31:0]      acc_wdata_c;

    // Access strobe for the edge entering ACK; with zero wait that edge is the accept edge,
    // so the live bus fields are used instead of the not-yet-latched copies.
    always_comb begin
        go_ack_c    = 1'b0;
        acc_idx_c   = idx_q;
        acc_cmd_c   = cmd_q;
        acc_wdata_c = wdata_q;
        if (state == IDLE) begin
            acc_idx_c   = bus.addr[IDX_W+1:2];
            acc_cmd_c   = bus.cmd;
            acc_wdata_c = bus.wdata;
            go_ack_c    = !reset && bus.req && ZERO_WAIT;
        end else if (state == WAIT) begin
            go_ack_c    = !reset && (cnt == CNT_W'(1));
        end
    end

    // Memory array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (go_ack_c && acc_cmd_c) begin
            mem[acc_idx_c] <= acc_wdata_c;
        end
    end

    // Transaction FSM with registered ack and read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            cmd_q   <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= (state == ACK);
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        idx_q   <= bus.addr[IDX_W+1:2];
                        cmd_q   <= bus.cmd;
                        wdata_q <= bus.wdata;
                        cnt     <= CNT_W'(WAIT_CYCLES);
                        state   <= ZERO_WAIT ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= ACK;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (go_ack_c && !acc_cmd_c) begin
                rdata_q <= mem[acc_idx_c];
            end
        end
    end

    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_bus_mem_slave.sv
// Directed bench for bus_mem_slave: vector table on a 2-wait instance, corner sequences on both.
module tb_bus_mem_slave;
    logic clk;
    logic reset;

    bus_mem_if bus ();
    bus_mem_if bus0 ();

    bus_mem_slave #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    bus_mem_slave #(.DEPTH(4), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        disturb;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];
    int   nvec;
    int   nfail;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one request (caller is just after a negedge), check latency, rdata and pulse width.
    task automatic run_vec(input vec_t v, input string name);
        int  lat;
        int  n;
        bit  seen;
        bus.req   = 1'b1;
        bus.cmd   = v.cmd;
        bus.addr  = v.addr;
        bus.wdata = v.wdata;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        if (v.disturb) begin
            bus.addr  = 32'h0000_0020;
            bus.wdata = 32'h0000_0099;
            bus.cmd   = ~v.cmd;
        end
        lat  = 0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.ack === 1'b1) begin
                seen = 1'b1;
                lat  = n;
            end
        end
        check32({name, "_latency"}, 32'(lat), 32'd3);
        check32({name, "_rdata"}, bus.rdata, v.exp_rdata);
        @(posedge clk);
        #1;
        check32({name, "_ack_width"}, 32'(bus.ack), 32'd0);
    endtask

    logic [31:0] s2_rd [8];

    initial begin
        nvec  = 0;
        nfail = 0;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0400, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h1234_5678};
        vecs[4]  = '{1'b1, 32'h0000_0014, 32'h0000_00AA, 1'b0, 32'h1234_5678};
        vecs[5]  = '{1'b0, 32'h0000_0017, 32'h0000_0000, 1'b0, 32'h0000_00AA};
        vecs[6]  = '{1'b1, 32'h0000_0008, 32'hCAFE_F00D, 1'b0, 32'h0000_00AA};
        vecs[7]  = '{1'b0, 32'h0000_0008, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
        vecs[8]  = '{1'b1, 32'hFFFF_FC04, 32'h1111_1111, 1'b0, 32'hCAFE_F00D};
        vecs[9]  = '{1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'h1111_1111};
        vecs[10] = '{1'b1, 32'h0000_0020, 32'h2020_2020, 1'b0, 32'h1111_1111};
        vecs[11] = '{1'b1, 32'h0000_001C, 32'h0000_0077, 1'b1, 32'h1111_1111};
        vecs[12] = '{1'b0, 32'h0000_001C, 32'h0000_0000, 1'b0, 32'h0000_0077};
        vecs[13] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h2020_2020};

        s2_rd = '{32'h0, 32'h0, 32'hA5A5_0001, 32'hA5A5_0001,
                  32'hA5A5_0001, 32'hA5A5_0001, 32'h5A5A_0002, 32'h5A5A_0002};

        reset      = 1'b1;
        bus.req    = 1'b0;
        bus.cmd    = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        bus0.req   = 1'b0;
        bus0.cmd   = 1'b0;
        bus0.addr  = '0;
        bus0.wdata = '0;

        // Reset state on both instances.
        repeat (3) @(posedge clk);
        #1;
        check32("reset_ack", 32'(bus.ack), 32'd0);
        check32("reset_rdata", bus.rdata, 32'h0);
        check32("reset_ack0", 32'(bus0.ack), 32'd0);
        check32("reset_rdata0", bus0.rdata, 32'h0);

        // First request is presented together with reset release.
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            if (i != 0) @(negedge clk);
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during WAIT of a write to index 5 aborts it.
        @(negedge clk);
        bus.req   = 1'b1;
        bus.cmd   = 1'b1;
        bus.addr  = 32'h0000_0014;
        bus.wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        check32("abort_ack_in_reset", 32'(bus.ack), 32'd0);
        check32("abort_rdata_in_reset", bus.rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        run_vec('{1'b0, 32'h0000_0014, 32'h0, 1'b0, 32'h0000_00AA}, "abort_readback");

        // Zero-wait instance with req held high, alternating write and read.
        @(negedge clk);
        bus0.req   = 1'b1;
        bus0.cmd   = 1'b1;
        bus0.addr  = 32'h0000_0000;
        bus0.wdata = 32'hA5A5_0001;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check32($sformatf("zw_ack_%0d", i), 32'(bus0.ack), 32'(i % 2));
            check32($sformatf("zw_rdata_%0d", i), bus0.rdata, s2_rd[i]);
            if (i % 2 == 0) begin
                @(negedge clk);
                case (i)
                    0: begin bus0.cmd = 1'b0; bus0.addr = 32'h0000_0000; end
                    2: begin bus0.cmd = 1'b1; bus0.addr = 32'h0000_0014; bus0.wdata = 32'h5A5A_0002; end
                    4: begin bus0.cmd = 1'b0; bus0.addr = 32'h0000_0004; end
                    default: bus0.req = 1'b0;
                endcase
            end
        end
        @(posedge clk);
        #1;
        check32("zw_ack_idle", 32'(bus0.ack), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
